// File: rtl/seed_fifo_param.sv
// seed_fifo_param: parametrised FIFO of (subject, query, length) seed
// triples with registered pop output, occupancy count and almost-full flag.
// Ports: clk, rst (async active-low); push side wr_en, buf_in_s/q/l;
// pop side rd_en, buf_out_s/q/l, out_valid; status buf_empty, buf_full,
// buf_afull, fifo_counter; drop stats drop_clr, ovf_cnt, zlen_cnt.
// Optional build macro SEED_FIFO_DROP_STATS_EN enables the drop counters;
// without it ovf_cnt/zlen_cnt read 0 and drop_clr is ignored.
module seed_fifo_param #(
  parameter int POS_W    = 8,
  parameter int LEN_W    = 8,
  parameter int ADDR_W   = 2,
  parameter int AFULL_TH = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [POS_W-1:0]  buf_in_s,
  input  logic [POS_W-1:0]  buf_in_q,
  input  logic [LEN_W-1:0]  buf_in_l,
  input  logic              rd_en,
  output logic [POS_W-1:0]  buf_out_s,
  output logic [POS_W-1:0]  buf_out_q,
  output logic [LEN_W-1:0]  buf_out_l,
  output logic              out_valid,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              buf_afull,
  output logic [ADDR_W:0]   fifo_counter,
  input  logic              drop_clr,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic [CNT_W-1:0]  zlen_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int EW    = 2 * POS_W + LEN_W;

  logic [EW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              len_nz;
  logic              push;
  logic              pop;

  assign len_nz = |buf_in_l;

  // Full/empty come from the registered count, so a pop in the
  // same cycle never frees room for a push and vice versa.
  assign push = wr_en && len_nz && !buf_full;
  assign pop  = rd_en && !buf_empty;

  assign fifo_counter = count;
  assign buf_empty = (count == '0);
  assign buf_full  = (count == (ADDR_W+1)'(DEPTH));
  assign buf_afull = (count >= (ADDR_W+1)'(AFULL_TH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {buf_in_s, buf_in_q, buf_in_l};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      buf_out_s <= '0;
      buf_out_q <= '0;
      buf_out_l <= '0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        {buf_out_s, buf_out_q, buf_out_l} <= mem[rd_ptr];
      end else begin
        buf_out_s <= '0;
        buf_out_q <= '0;
        buf_out_l <= '0;
      end
    end
  end

`ifdef SEED_FIFO_DROP_STATS_EN
  logic ovf_inc;
  logic zlen_inc;

  assign ovf_inc  = wr_en && len_nz && buf_full;
  assign zlen_inc = wr_en && !len_nz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt  <= '0;
      zlen_cnt <= '0;
    end else if (drop_clr) begin
      ovf_cnt  <= '0;
      zlen_cnt <= '0;
    end else begin
      if (ovf_inc && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + 1'b1;
      if (zlen_inc && zlen_cnt != '1)
        zlen_cnt <= zlen_cnt + 1'b1;
    end
  end
`else
  logic unused_drop_clr;

  assign unused_drop_clr = drop_clr;
  assign ovf_cnt  = '0;
  assign zlen_cnt = '0;
`endif

endmodule
